// File: rtl/audio_pwm_pkg.sv
// Shared definitions for the multi-channel audio PWM engine: default
// parameter values, the per-channel gain ramp direction, and the helper
// functions used by the channel datapath.
package audio_pwm_pkg;

  localparam int unsigned DEF_CHANNELS  = 2;
  localparam int unsigned DEF_SAMPLE_W  = 16;
  localparam int unsigned DEF_GAIN_W    = 16;
  localparam int unsigned DEF_PWM_W     = 7;
  localparam int unsigned DEF_RAMP_STEP = 256;

  // Helper operands are carried in fixed wide containers; callers cast the
  // result back to their own width. Gains are limited to 32 bits and scaled
  // samples to 64 bits by these containers.
  localparam int unsigned RAMP_FN_W = 33;
  localparam int unsigned OB_FN_W   = 64;

  // Direction of the gain ramp for one channel at a sample strobe.
  typedef enum logic [1:0] {
    RAMP_HOLD = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_e;

  // Two's-complement to offset binary: flip the sign bit of a w-bit value.
  function automatic logic [OB_FN_W-1:0] to_offset_binary(
    input logic [OB_FN_W-1:0] y,
    input int unsigned        w
  );
    return y ^ (OB_FN_W'(1) << (w - 1));
  endfunction

  // One ramp step towards the target, clamped so it never overshoots.
  // The container is one bit wider than any gain, so g + step cannot wrap.
  function automatic logic [RAMP_FN_W-1:0] sat_step(
    input logic [RAMP_FN_W-1:0] g,
    input logic [RAMP_FN_W-1:0] t,
    input logic [RAMP_FN_W-1:0] step,
    input ramp_state_e          dir
  );
    logic [RAMP_FN_W-1:0] r;
    r = g;
    case (dir)
      RAMP_UP: begin
        r = g + step;
        if (r > t) r = t;
      end
      RAMP_DOWN: begin
        r = (g > t + step) ? (g - step) : t;
      end
      default: r = g;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/audio_pwm_channel.sv
// One audio channel: sample capture, click-free gain ramp, sign/magnitude
// scaling, error-feedback quantizer and PWM comparator.
//
// Ports:
//   Clk, nReset  - clock, synchronous active-low reset
//   Sample_Ena   - sample-rate strobe (capture + ramp step)
//   Frame_Ena    - frame-rate strobe (quantizer update)
//   Audio        - signed PCM sample for this channel
//   Volume       - target gain for this channel
//   Mute         - forces the target gain to 0
//   Active       - PWM output enable
//   Count        - shared frame counter
//   PWM          - registered PWM output
//   Level        - registered quantized level
//   Gain_Zero_c  - combinational: current gain is 0
module audio_pwm_channel
  import audio_pwm_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = DEF_SAMPLE_W,
  parameter int unsigned GAIN_W    = DEF_GAIN_W,
  parameter int unsigned PWM_W     = DEF_PWM_W,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic                Sample_Ena,
  input  logic                Frame_Ena,
  input  logic [SAMPLE_W-1:0] Audio,
  input  logic [GAIN_W-1:0]   Volume,
  input  logic                Mute,
  input  logic                Active,
  input  logic [PWM_W:0]      Count,
  output logic                PWM,
  output logic [PWM_W-1:0]    Level,
  output logic                Gain_Zero_c
);

  localparam int unsigned Y_W = SAMPLE_W + GAIN_W;
  localparam int unsigned E_W = Y_W - PWM_W;

  logic                s_q;
  logic [SAMPLE_W-1:0] a_q;
  logic [GAIN_W-1:0]   g_q;
  logic [GAIN_W-1:0]   g_lag_q;
  logic                cap_d1_q;
  logic                cap_d2_q;
  logic                s_p_q;
  logic [Y_W-1:0]      p_q;
  logic [Y_W-1:0]      y_q;
  logic [E_W-1:0]      e_q;
  logic [PWM_W-1:0]    level_q;
  logic                pwm_q;

  ramp_state_e         ramp_c;
  logic [GAIN_W-1:0]   target_c;
  logic [GAIN_W-1:0]   g_next_c;
  logic [SAMPLE_W-1:0] mag_c;
  logic [Y_W-1:0]      u_c;
  logic [Y_W:0]        acc_c;

  // Ramp decision, sample magnitude and quantizer sum.
  always_comb begin
    target_c = Mute ? '0 : Volume;
    ramp_c   = RAMP_HOLD;
    if (g_q < target_c)      ramp_c = RAMP_UP;
    else if (g_q > target_c) ramp_c = RAMP_DOWN;
    g_next_c = GAIN_W'(sat_step(RAMP_FN_W'(g_q), RAMP_FN_W'(target_c),
                                RAMP_FN_W'(RAMP_STEP), ramp_c));
    // The most negative sample maps to 2^(SAMPLE_W-1), which still fits unsigned.
    mag_c    = Audio[SAMPLE_W-1] ? (~Audio + SAMPLE_W'(1)) : Audio;
    u_c      = Y_W'(to_offset_binary(OB_FN_W'(y_q), Y_W));
    acc_c    = {1'b0, u_c} + {{(PWM_W + 1){1'b0}}, e_q};
  end

  // Capture -> multiply (t+1) -> sign restore (t+2); quantizer on frames.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      s_q      <= 1'b0;
      a_q      <= '0;
      g_q      <= '0;
      g_lag_q  <= '0;
      cap_d1_q <= 1'b0;
      cap_d2_q <= 1'b0;
      s_p_q    <= 1'b0;
      p_q      <= '0;
      y_q      <= '0;
      e_q      <= '0;
      level_q  <= '0;
      pwm_q    <= 1'b0;
    end else begin
      cap_d1_q <= Sample_Ena;
      cap_d2_q <= cap_d1_q;

      if (Sample_Ena) begin
        s_q     <= Audio[SAMPLE_W-1];
        a_q     <= mag_c;
        // The product uses the gain in force before this strobe's step.
        g_lag_q <= g_q;
        g_q     <= g_next_c;
      end

      if (cap_d1_q) begin
        p_q   <= Y_W'(a_q) * Y_W'(g_lag_q);
        s_p_q <= s_q;
      end

      if (cap_d2_q) begin
        y_q <= s_p_q ? (~p_q + Y_W'(1)) : p_q;
      end

      // A carry means the level would exceed full scale: pin it and keep
      // the residual error so the next frame is not disturbed.
      if (Frame_Ena) begin
        if (acc_c[Y_W]) begin
          level_q <= '1;
        end else begin
          level_q <= acc_c[Y_W-1 -: PWM_W];
          e_q     <= acc_c[E_W-1:0];
        end
      end

      pwm_q <= Active & ({1'b0, level_q} > Count);
    end
  end

  assign PWM         = pwm_q;
  assign Level       = level_q;
  assign Gain_Zero_c = (g_q == '0);

endmodule

// File: rtl/audio_pwm_engine.sv
// Multi-channel scale-and-PWM audio output engine. Instantiates one
// audio_pwm_channel per channel and owns the shared frame counter and the
// all-channels-silent (Muted) flag.
//
// Ports:
//   Clk, nReset  - clock, synchronous active-low reset
//   Sample_Ena   - one-cycle strobe at the sample rate
//   Frame_Ena    - one-cycle strobe at the PWM frame rate
//   Audio        - packed signed samples, channel 0 in the LSBs
//   Volume       - packed target gains, channel 0 in the LSBs
//   Mute         - ramps every channel's gain to 0
//   Active       - PWM output enable (pins only)
//   PWM          - one registered PWM output per channel
//   Level        - packed registered quantized levels
//   Muted        - registered: every channel's gain is 0
module audio_pwm_engine
  import audio_pwm_pkg::*;
#(
  parameter int unsigned CHANNELS  = DEF_CHANNELS,
  parameter int unsigned SAMPLE_W  = DEF_SAMPLE_W,
  parameter int unsigned GAIN_W    = DEF_GAIN_W,
  parameter int unsigned PWM_W     = DEF_PWM_W,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic                         Clk,
  input  logic                         nReset,
  input  logic                         Sample_Ena,
  input  logic                         Frame_Ena,
  input  logic [CHANNELS*SAMPLE_W-1:0] Audio,
  input  logic [CHANNELS*GAIN_W-1:0]   Volume,
  input  logic                         Mute,
  input  logic                         Active,
  output logic [CHANNELS-1:0]          PWM,
  output logic [CHANNELS*PWM_W-1:0]    Level,
  output logic                         Muted
);

  localparam int unsigned CNT_W = PWM_W + 1;

  logic [CNT_W-1:0]    count_q;
  logic                muted_q;
  logic [CHANNELS-1:0] gain_zero_c;

  // Frame counter restarts each frame and saturates, so an overlong frame
  // holds every output low instead of wrapping into a second pulse.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      count_q <= '0;
      muted_q <= 1'b1;
    end else begin
      if (Frame_Ena)            count_q <= '0;
      else if (count_q != '1)   count_q <= count_q + CNT_W'(1);
      muted_q <= &gain_zero_c;
    end
  end

  assign Muted = muted_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    audio_pwm_channel #(
      .SAMPLE_W  (SAMPLE_W),
      .GAIN_W    (GAIN_W),
      .PWM_W     (PWM_W),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .Clk         (Clk),
      .nReset      (nReset),
      .Sample_Ena  (Sample_Ena),
      .Frame_Ena   (Frame_Ena),
      .Audio       (Audio[c*SAMPLE_W +: SAMPLE_W]),
      .Volume      (Volume[c*GAIN_W +: GAIN_W]),
      .Mute        (Mute),
      .Active      (Active),
      .Count       (count_q),
      .PWM         (PWM[c]),
      .Level       (Level[c*PWM_W +: PWM_W]),
      .Gain_Zero_c (gain_zero_c[c])
    );
  end

endmodule

// File: tb/tb_audio_pwm_engine.sv
// Directed bench for audio_pwm_engine with a transaction-level model and a
// scoreboard of expected per-frame levels.
module tb_audio_pwm_engine;

  localparam int unsigned CH   = 4;
  localparam int unsigned SW   = 16;
  localparam int unsigned GW   = 16;
  localparam int unsigned PW   = 7;
  localparam int unsigned STEP = 256;
  localparam int unsigned YW   = SW + GW;
  localparam int unsigned EW   = YW - PW;
  localparam int          FLEN = 130;

  logic             Clk = 1'b0;
  logic             nReset;
  logic             Sample_Ena;
  logic             Frame_Ena;
  logic [CH*SW-1:0] Audio;
  logic [CH*GW-1:0] Volume;
  logic             Mute;
  logic             Active;
  logic [CH-1:0]    PWM;
  logic [CH*PW-1:0] Level;
  logic             Muted;

  always #10 Clk = ~Clk;

  audio_pwm_engine #(
    .CHANNELS  (CH),
    .SAMPLE_W  (SW),
    .GAIN_W    (GW),
    .PWM_W     (PW),
    .RAMP_STEP (STEP)
  ) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .Sample_Ena (Sample_Ena),
    .Frame_Ena  (Frame_Ena),
    .Audio      (Audio),
    .Volume     (Volume),
    .Mute       (Mute),
    .Active     (Active),
    .PWM        (PWM),
    .Level      (Level),
    .Muted      (Muted)
  );

  // Reference state per channel.
  logic [GW-1:0] m_g   [CH];
  logic [YW-1:0] m_y   [CH];
  logic [EW-1:0] m_e   [CH];
  logic [PW-1:0] m_lvl [CH];

  logic [CH*PW-1:0] exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [GW-1:0] ramp(input logic [GW-1:0] g, input logic [GW-1:0] t);
    int gi, ti, st;
    gi = int'(g);
    ti = int'(t);
    st = int'(STEP);
    if (gi < ti) return GW'((gi + st > ti) ? ti : gi + st);
    if (gi > ti) return GW'((gi - st < ti) ? ti : gi - st);
    return g;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_g[c]   = '0;
      m_y[c]   = '0;
      m_e[c]   = '0;
      m_lvl[c] = '0;
    end
  endtask

  // Sample strobe: scale with the gain before this step, then step the gain.
  task automatic model_sample();
    for (int c = 0; c < CH; c++) begin
      logic signed [SW-1:0] x;
      logic [GW-1:0]        tgt;
      longint               mag, prod;
      x    = Audio[c*SW +: SW];
      mag  = (x < 0) ? -longint'(x) : longint'(x);
      prod = mag * longint'(m_g[c]);
      m_y[c] = YW'((x < 0) ? -prod : prod);
      tgt    = Mute ? '0 : Volume[c*GW +: GW];
      m_g[c] = ramp(m_g[c], tgt);
    end
  endtask

  task automatic model_frame();
    for (int c = 0; c < CH; c++) begin
      logic [YW:0] acc;
      acc = {1'b0, m_y[c] ^ 32'h8000_0000} + {8'b0, m_e[c]};
      if (acc[YW]) begin
        m_lvl[c] = '1;
      end else begin
        m_lvl[c] = acc[YW-1 -: PW];
        m_e[c]   = acc[EW-1:0];
      end
    end
  endtask

  function automatic logic [CH*PW-1:0] pack_lvl();
    logic [CH*PW-1:0] v;
    for (int c = 0; c < CH; c++) v[c*PW +: PW] = m_lvl[c];
    return v;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One clock with the given strobes; frames push/pop the scoreboard.
  // The frame is modelled before the sample so a colliding frame sees old Y.
  task automatic pulse(input logic se, input logic fe);
    Sample_Ena = se;
    Frame_Ena  = fe;
    if (fe) begin
      model_frame();
      exp_q.push_back(pack_lvl());
    end
    if (se) model_sample();
    tick();
    Sample_Ena = 1'b0;
    Frame_Ena  = 1'b0;
    if (fe) begin
      if (exp_q.size() > 0) begin
        check("level", 64'(Level), 64'(exp_q.pop_front()));
      end else begin
        n_checks++;
        $error("FAIL scoreboard: observed empty expected entry");
      end
    end
  endtask

  // A frame of FLEN clocks, counting high PWM cycles per channel.
  task automatic frame_run();
    int hi [CH];
    pulse(1'b0, 1'b1);
    for (int c = 0; c < CH; c++) hi[c] = 0;
    for (int i = 1; i < FLEN; i++) begin
      tick();
      for (int c = 0; c < CH; c++) hi[c] += int'(PWM[c]);
    end
    for (int c = 0; c < CH; c++)
      check($sformatf("pwm_high_ch%0d", c), 64'(hi[c]), Active ? 64'(m_lvl[c]) : 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nReset     = 1'b0;
    Sample_Ena = 1'b0;
    Frame_Ena  = 1'b0;
    Mute       = 1'b0;
    Active     = 1'b1;
    Audio      = {CH{16'h1234}};
    Volume     = {CH{16'd1024}};
    model_reset();

    // Reset held 3 clocks, strobes toggling underneath it.
    tick();
    Sample_Ena = 1'b1;
    Frame_Ena  = 1'b1;
    tick();
    Sample_Ena = 1'b0;
    Frame_Ena  = 1'b0;
    tick();
    check("reset_pwm",   64'(PWM),   64'd0);
    check("reset_level", 64'(Level), 64'd0);
    check("reset_muted", 64'(Muted), 64'd1);

    // Ramp up from silence to 1024 in four strobes.
    nReset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      pulse(1'b1, 1'b0);
      check("ramp_up_g", 64'(dut.g_ch[0].u_ch.g_q), 64'(256 * k));
      idle(2);
      if (k == 1) check("unmuted", 64'(Muted), 64'd0);
    end
    idle(1);
    frame_run();
    frame_run();

    // Mute ramp down to zero; Muted follows one clock later.
    Mute = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      pulse(1'b1, 1'b0);
      check("mute_g", 64'(dut.g_ch[0].u_ch.g_q), 64'(1024 - 256 * k));
      if (k == 4) begin
        check("muted_lag", 64'(Muted), 64'd0);
        tick();
        check("muted_set", 64'(Muted), 64'd1);
      end
      idle(2);
    end
    Mute = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      pulse(1'b1, 1'b0);
      idle(2);
    end
    check("unmute_g", 64'(dut.g_ch[0].u_ch.g_q), 64'd1024);

    // Mute released mid-ramp redirects back up.
    Mute = 1'b1;
    pulse(1'b1, 1'b0); idle(2);
    pulse(1'b1, 1'b0); idle(2);
    check("redir_low", 64'(dut.g_ch[0].u_ch.g_q), 64'd512);
    Mute = 1'b0;
    pulse(1'b1, 1'b0); idle(2);
    check("redir_up1", 64'(dut.g_ch[0].u_ch.g_q), 64'd768);
    pulse(1'b1, 1'b0); idle(2);
    check("redir_up2", 64'(dut.g_ch[0].u_ch.g_q), 64'd1024);

    // Zero audio at full gain sits at mid-scale.
    Audio  = '0;
    Volume = {CH{16'hFFFF}};
    for (int k = 0; k < 300; k++) begin
      if (m_g[0] == 16'hFFFF) break;
      pulse(1'b1, 1'b0);
      idle(2);
    end
    check("full_gain", 64'(dut.g_ch[0].u_ch.g_q), 64'hFFFF);
    pulse(1'b1, 1'b0);
    idle(3);
    frame_run();
    check("zero_level", 64'(Level[PW-1:0]), 64'd64);
    frame_run();

    // Positive full scale: saturating level with no glitch.
    Audio = {CH{16'h7FFF}};
    pulse(1'b1, 1'b0);
    idle(3);
    check("y_pos_full", 64'(dut.g_ch[0].u_ch.y_q), 64'h7FFE_8001);
    for (int f = 0; f < 3; f++) begin
      frame_run();
      check("pos_full_level", 64'(Level[PW-1:0]), 64'd127);
    end

    // Most negative sample.
    Audio = {CH{16'h8000}};
    pulse(1'b1, 1'b0);
    idle(3);
    check("y_neg_full", 64'(dut.g_ch[0].u_ch.y_q), 64'h8000_8000);
    for (int f = 0; f < 3; f++) frame_run();

    // Sample and frame on the same edge: frame uses the old Y.
    Audio = {16'h0100, 16'h2000, 16'hF000, 16'h0400};
    pulse(1'b1, 1'b1);
    idle(3);
    frame_run();

    // Output gating: levels keep moving while pins stay low.
    Active = 1'b0;
    frame_run();
    frame_run();
    Active = 1'b1;
    frame_run();

    // Independent channels with distinct gains and samples.
    Volume = {16'h2000, 16'hC000, 16'h8000, 16'h4000};
    Audio  = {16'hFF00, 16'h7000, 16'hDCBB, 16'h1234};
    for (int k = 0; k < 12; k++) begin
      pulse(1'b1, 1'b0);
      idle(3);
      pulse(1'b0, 1'b1);
      idle(4);
    end
    frame_run();

    // Reset in the middle of a frame.
    pulse(1'b0, 1'b1);
    idle(40);
    nReset = 1'b0;
    tick();
    check("midrst_pwm",   64'(PWM),   64'd0);
    check("midrst_level", 64'(Level), 64'd0);
    check("midrst_muted", 64'(Muted), 64'd1);
    nReset = 1'b1;
    model_reset();
    exp_q.delete();
    idle(2);
    frame_run();
    check("post_rst_muted", 64'(Muted), 64'd1);
    for (int k = 0; k < 6; k++) begin
      pulse(1'b1, 1'b0);
      idle(3);
      pulse(1'b0, 1'b1);
      idle(3);
    end
    frame_run();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_pwm_engine.md
Name: audio_pwm_engine

Overview:
Multi-channel successor to the amplifier's fixed two-channel scale-and-PWM output path. It captures one PCM sample per channel at the sample strobe and applies a per-channel log-volume gain. The gain ramps between values instead of stepping, so mute, unmute and volume changes are click-free. Each channel's scaled sample is quantized to PWM_W bits with first-order error feedback at the frame rate, and one PWM output per channel is driven from a shared frame counter.

Parameters:
CHANNELS, 2, number of audio channels
SAMPLE_W, 16, signed PCM sample width
GAIN_W, 16, unsigned gain width (output of the log-volume table)
PWM_W, 7, PWM level width; the frame counter is PWM_W+1 bits
RAMP_STEP, 256, gain change per Sample_Ena while ramping

Ports:
Clk  in  1  system clock (50 MHz)
nReset  in  1  synchronous, active-low reset
Sample_Ena  in  1  one-cycle strobe at the sample rate (48 kHz)
Frame_Ena  in  1  one-cycle strobe at the PWM frame rate (384 kHz)
Audio  in  CHANNELS*SAMPLE_W  packed signed samples, channel 0 in the LSBs
Volume  in  CHANNELS*GAIN_W  packed target gains
Mute  in  1  forces every target gain to 0
Active  in  1  output enable; when 0, PWM is forced low
PWM  out  CHANNELS  PWM outputs
Level  out  CHANNELS*PWM_W  current quantized level, for observability
Muted  out  1  high when every channel's effective gain is 0

Behaviour:
- Reset (nReset=0 at a Clk edge) clears the following to 0: PWM, Level, Muted-source gains G[c], error accumulators, captured samples and the frame counter. Muted therefore reads 1 during and after reset, and playback after reset always ramps up from silence.
- A reset asserted mid-ramp or mid-frame aborts that activity immediately. There is no partial state.
- Sample capture (edge t, Sample_Ena=1): latch sign S[c] and magnitude A[c]=|Audio[c]|, held in SAMPLE_W bits unsigned. A sample of -2^(SAMPLE_W-1) is valid and gives magnitude 2^(SAMPLE_W-1).
- Gain ramp: on the same edge as capture, T = Mute ? 0 : Volume[c]. Per-channel state is HOLD, UP or DOWN:
  - G<T: state UP, G <= min(G+RAMP_STEP, T).
  - G>T: state DOWN, G <= max(G-RAMP_STEP, T).
  - G==T: state HOLD.
  - The arithmetic is GAIN_W+1 bits wide, so there is no wrap-around.
  - A target change mid-ramp redirects on the next strobe.
- Scale pipeline:
  - t+1: P[c] = A[c]*G[c], unsigned, SAMPLE_W+GAIN_W bits. This uses the pre-update G, which sets a one-sample gain lag.
  - t+2: Y[c] = S[c] ? -P[c] : P[c], signed, SAMPLE_W+GAIN_W bits. It cannot overflow.
  - Y is held until the next capture.
- Quantizer (Frame_Ena=1):
  - U = Y with the MSB inverted (offset binary).
  - Acc = U + E, one bit wider than U.
  - If the carry bit is set, Level = all ones (saturate) and E is left unchanged. Otherwise Level = Acc top PWM_W bits and E = Acc remaining low bits.
- Simultaneous Sample_Ena and Frame_Ena: the quantizer uses the previous Y. Register ordering defines this; no arbitration is needed.
- Frame counter: cleared to 0 on Frame_Ena. Otherwise it increments and saturates at all ones; it never wraps.
- PWM[c] <= Active & ({1'b0,Level[c]} > count), registered.
  - Level 0 gives a constant low.
  - Frame length L clocks gives min(Level, L) high cycles per frame.
- Muted is registered: it reads 1 one cycle after every G[c] is 0.
- Active has no effect on the internal state; only the PWM pin is gated.

Decomposition:
- Shared package audio_pwm_pkg holds:
  - the default parameter constants;
  - the ramp-state enum (HOLD, UP, DOWN);
  - the function to_offset_binary();
  - the function sat_step() for the clamped ramp.
- One sub-module, audio_pwm_channel, holds capture, ramp, multiply, sign restore, quantizer and comparator for one channel. The top generates CHANNELS instances and owns the shared frame counter and the Muted reduction.

Test Plan:
- Reset: hold nReset=0 for 3 clocks with Active=1 and Audio non-zero -> PWM=0, Level=0, Muted=1. Release with Volume=1024, RAMP_STEP=256, Mute=0 -> G reaches 1024 exactly after 4 Sample_Ena, Muted falls to 0.
- Mute ramp: G=1024, Mute=1 -> G=768, 512, 256, 0 on successive strobes, Muted=1 one cycle after the 4th. Deassert Mute after the 2nd strobe -> G goes back to 768, then 1024.
- Zero audio: Audio=0, G=0xFFFF, Frame_Ena every 130 clocks -> Level=64 every frame, PWM high 64 clocks per frame.
- Full scale: Audio=0x7FFF, G=0xFFFF -> Y=0x7FFE8001, Level=127 with no saturation glitch, PWM high 127 clocks per frame. Audio=0x8000 -> Y=0x80008000, Level=0 and PWM constantly low for the first frames.
- Collisions and gating: Sample_Ena and Frame_Ena on the same edge -> Level reflects the old sample. Active=0 for 2 frames -> PWM=0 while Level keeps updating, and the first frame after re-enable matches a reference model.
- Channel independence: CHANNELS=4 with distinct Volume/Audio per channel plus mid-frame reset -> each Level matches the model, and all outputs are 0 the cycle after reset.
